// File: rtl/risc_bus_pkg.sv
// Shared encodings and default memory map for the CPU memory bus.
package risc_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StFault
    } bus_state_e;

    typedef enum logic [1:0] {
        RegionRom,
        RegionRam,
        RegionIo,
        RegionUnmapped
    } region_e;

    localparam logic [12:0] RAM_BASE = 13'h1800;
    localparam logic [12:0] IO_ADDR  = 13'h1FFF;

endpackage

// File: rtl/mem_bus_responder_if.sv
// CPU-side bus between the controller strobes, the ROM macro and the responder.
interface mem_bus_responder_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              datactl_ena;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [DATA_W-1:0] io_out;
    logic              bus_err;
    logic              rom_wr_err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;

    // CPU plus ROM side
    modport master (
        output addr, rd, wr, data_in, datactl_ena, rom_data,
        input  rom_addr, data_out, data_oe, io_out, bus_err, rom_wr_err, rd_count, wr_count
    );

    // Responder side
    modport slave (
        input  addr, rd, wr, data_in, datactl_ena, rom_data,
        output rom_addr, data_out, data_oe, io_out, bus_err, rom_wr_err, rd_count, wr_count
    );
endinterface

// File: rtl/resp_ram.sv
// Synchronous-write, asynchronous-read RAM array (contents not reset).
module resp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one word per enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: decodes the CPU address into ROM/RAM/IO, returns registered
// read data, commits one write per strobe, counts strobes and flags protocol faults.
module mem_bus_responder
    import risc_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 13,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RAM_BASE  = risc_bus_pkg::RAM_BASE,
    parameter int unsigned       RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] IO_ADDR   = risc_bus_pkg::IO_ADDR,
    parameter int unsigned       CNT_W     = 16
) (
    input logic               clk1,
    input logic               reset,
    mem_bus_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(RAM_DEPTH);

    bus_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic [DATA_W-1:0] io_q;
    logic              bus_err_q, bus_err_d;
    logic              rom_wr_err_q, rom_wr_err_d;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
    logic              rd_inc, wr_inc;
    logic              ram_we, io_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_data;
    region_e           region;

    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - RAM_BASE;
        if (a < RAM_BASE)                return RegionRom;
        if (a == IO_ADDR)                return RegionIo;
        if (off < ADDR_W'(RAM_DEPTH))    return RegionRam;
        return RegionUnmapped;
    endfunction

    assign region   = decode(bus.addr);
    assign ram_idx  = IDX_W'(bus.addr - RAM_BASE);
    assign bus.rom_addr = bus.addr;

    resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk   (clk1),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (bus.data_in),
        .rdata (ram_rdata)
    );

    // Read data mux for the decoded region
    always_comb begin
        rd_data = '1;
        unique case (region)
            RegionRom: rd_data = bus.rom_data;
            RegionRam: rd_data = ram_rdata;
            RegionIo:  rd_data = io_q;
            default:   rd_data = '1;
        endcase
    end

    // Next-state, commit strobes and registered-output next values
    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        data_oe_d    = 1'b0;
        bus_err_d    = 1'b0;
        rom_wr_err_d = 1'b0;
        ram_we       = 1'b0;
        io_we        = 1'b0;
        rd_inc       = 1'b0;
        wr_inc       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.rd && bus.wr) begin
                    state_d   = StFault;
                    bus_err_d = 1'b1;
                end else if (bus.rd) begin
                    state_d    = StRead;
                    data_out_d = rd_data;
                    data_oe_d  = 1'b1;
                    rd_inc     = 1'b1;
                end else if (bus.wr && bus.datactl_ena) begin
                    state_d = StWrite;
                    wr_inc  = 1'b1;
                    unique case (region)
                        RegionRam: ram_we       = 1'b1;
                        RegionIo:  io_we        = 1'b1;
                        RegionRom: rom_wr_err_d = 1'b1;
                        default:   ;
                    endcase
                end else if (bus.wr) begin
                    state_d   = StFault;
                    bus_err_d = 1'b1;
                end
            end
            StRead: begin
                if (bus.wr) begin
                    state_d   = StFault;
                    bus_err_d = 1'b1;
                end else if (bus.rd) begin
                    data_out_d = rd_data;
                    data_oe_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (bus.rd) begin
                    state_d   = StFault;
                    bus_err_d = 1'b1;
                end else if (!bus.wr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (!bus.rd && !bus.wr) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State, registered outputs and saturating counters
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            io_q         <= '0;
            bus_err_q    <= 1'b0;
            rom_wr_err_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            bus_err_q    <= bus_err_d;
            rom_wr_err_q <= rom_wr_err_d;
            if (io_we) begin
                io_q <= bus.data_in;
            end
            if (rd_inc && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
            if (wr_inc && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_oe    = data_oe_q;
    assign bus.io_out     = io_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.rom_wr_err = rom_wr_err_q;
    assign bus.rd_count   = rd_cnt_q;
    assign bus.wr_count   = wr_cnt_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder; a second narrow-counter instance shares the
// same stimulus to exercise counter saturation.
module tb_mem_bus_responder;
    logic        clk1 = 1'b0;
    logic        reset;
    logic [12:0] addr;
    logic        rd, wr, datactl_ena;
    logic [7:0]  data_in;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_bus_responder_if #(.ADDR_W(13), .DATA_W(8), .CNT_W(16)) bus ();
    mem_bus_responder_if #(.ADDR_W(13), .DATA_W(8), .CNT_W(2))  bus_s ();

    // ROM model: 8'h3C at 13'h0010, low address byte elsewhere
    function automatic logic [7:0] rom_model(input logic [12:0] a);
        return (a == 13'h0010) ? 8'h3C : a[7:0];
    endfunction

    assign bus.addr          = addr;
    assign bus.rd            = rd;
    assign bus.wr            = wr;
    assign bus.data_in       = data_in;
    assign bus.datactl_ena   = datactl_ena;
    assign bus.rom_data      = rom_model(bus.rom_addr);
    assign bus_s.addr        = addr;
    assign bus_s.rd          = rd;
    assign bus_s.wr          = wr;
    assign bus_s.data_in     = data_in;
    assign bus_s.datactl_ena = datactl_ena;
    assign bus_s.rom_data    = rom_model(bus_s.rom_addr);

    mem_bus_responder #(.CNT_W(16)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_bus_responder #(.CNT_W(2)) dut_sat (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_bus();
        rd = 1'b0; wr = 1'b0; datactl_ena = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = 13'h1805; rd = 1'b1; wr = 1'b0;
        datactl_ena = 1'b0; data_in = 8'h00;

        // 1 Reset held with rd high
        tick(); tick();
        check("rst_oe",   32'(bus.data_oe), 32'h0);
        check("rst_io",   32'(bus.io_out), 32'h0);
        check("rst_rdc",  32'(bus.rd_count), 32'h0);
        check("rst_wrc",  32'(bus.wr_count), 32'h0);
        check("rst_err",  32'(bus.bus_err), 32'h0);
        idle_bus();
        reset = 1'b1;
        tick();

        // 2 RAM write (2-cycle strobe) then read
        addr = 13'h1805; data_in = 8'hA5; datactl_ena = 1'b1; wr = 1'b1;
        tick();
        check("ram_wr_cnt1", 32'(bus.wr_count), 32'd1);
        tick();
        check("ram_wr_cnt_hold", 32'(bus.wr_count), 32'd1);
        idle_bus(); tick();
        rd = 1'b1; tick();
        check("ram_rd_data", 32'(bus.data_out), 32'hA5);
        check("ram_rd_oe",   32'(bus.data_oe), 32'h1);
        check("ram_rd_cnt",  32'(bus.rd_count), 32'd1);
        rd = 1'b0; tick();
        check("ram_rd_oe_off", 32'(bus.data_oe), 32'h0);

        // 3 ROM read, re-sample while rd held, then ROM write
        addr = 13'h0010; rd = 1'b1; tick();
        check("rom_rd", 32'(bus.data_out), 32'h3C);
        addr = 13'h0011; tick();
        check("rom_resample", 32'(bus.data_out), 32'h11);
        check("rom_rd_cnt",   32'(bus.rd_count), 32'd2);
        rd = 1'b0; tick();
        addr = 13'h0010; data_in = 8'h77; datactl_ena = 1'b1; wr = 1'b1; tick();
        check("rom_wr_err",  32'(bus.rom_wr_err), 32'h1);
        check("rom_wr_cnt",  32'(bus.wr_count), 32'd2);
        tick();
        check("rom_wr_err_pulse", 32'(bus.rom_wr_err), 32'h0);
        idle_bus(); tick();

        // 4 IO register and unmapped region
        addr = 13'h1FFF; data_in = 8'h5A; datactl_ena = 1'b1; wr = 1'b1; tick();
        check("io_out", 32'(bus.io_out), 32'h5A);
        idle_bus(); tick();
        rd = 1'b1; tick();
        check("io_rd", 32'(bus.data_out), 32'h5A);
        rd = 1'b0; tick();
        addr = 13'h1900; rd = 1'b1; tick();
        check("unmap_rd", 32'(bus.data_out), 32'hFF);
        rd = 1'b0; tick();
        data_in = 8'h12; datactl_ena = 1'b1; wr = 1'b1; tick();
        check("unmap_wr_cnt", 32'(bus.wr_count), 32'd4);
        check("unmap_wr_rom_err", 32'(bus.rom_wr_err), 32'h0);
        check("unmap_io_keep", 32'(bus.io_out), 32'h5A);
        idle_bus(); tick();

        // 5 Faults: rd&wr together, then wr without datactl_ena
        addr = 13'h1805; data_in = 8'h00; datactl_ena = 1'b1; rd = 1'b1; wr = 1'b1; tick();
        check("flt_err", 32'(bus.bus_err), 32'h1);
        check("flt_oe",  32'(bus.data_oe), 32'h0);
        tick();
        check("flt_err_pulse", 32'(bus.bus_err), 32'h0);
        wr = 1'b0; datactl_ena = 1'b0; tick();
        check("flt_hold_oe",  32'(bus.data_oe), 32'h0);
        check("flt_hold_rdc", 32'(bus.rd_count), 32'd4);
        rd = 1'b0; tick();
        rd = 1'b1; tick();
        check("flt_ram_keep", 32'(bus.data_out), 32'hA5);
        check("flt_rdc",      32'(bus.rd_count), 32'd5);
        rd = 1'b0; tick();
        data_in = 8'h11; wr = 1'b1; datactl_ena = 1'b0; tick();
        check("noena_err", 32'(bus.bus_err), 32'h1);
        check("noena_wrc", 32'(bus.wr_count), 32'd4);
        idle_bus(); tick();
        rd = 1'b1; tick();
        check("noena_ram_keep", 32'(bus.data_out), 32'hA5);
        rd = 1'b0; tick();

        // 6 Long write strobe and saturation on the 2-bit instance
        addr = 13'h1801; data_in = 8'hC3; datactl_ena = 1'b1; wr = 1'b1; tick();
        data_in = 8'h99;
        tick(); tick(); tick();
        check("long_wr_cnt", 32'(bus.wr_count), 32'd5);
        idle_bus(); tick();
        check("sat_rdc_pre", 32'(bus_s.rd_count), 32'd3);
        rd = 1'b1; tick();
        check("long_wr_data", 32'(bus.data_out), 32'hC3);
        check("rd_cnt7",      32'(bus.rd_count), 32'd7);
        check("sat_rdc",      32'(bus_s.rd_count), 32'd3);
        check("sat_wrc",      32'(bus_s.wr_count), 32'd3);
        rd = 1'b0; tick();

        // Reset taken mid-strobe: strobe still high after release is a new read
        addr = 13'h1805; rd = 1'b1; tick();
        reset = 1'b0; #1;
        check("midrst_oe",  32'(bus.data_oe), 32'h0);
        check("midrst_rdc", 32'(bus.rd_count), 32'd0);
        #2; reset = 1'b1;
        tick();
        check("midrst_new_oe",   32'(bus.data_oe), 32'h1);
        check("midrst_new_data", 32'(bus.data_out), 32'hA5);
        check("midrst_new_rdc",  32'(bus.rd_count), 32'd1);
        rd = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
